// File: rtl/vram_fill.sv
// Rectangle-fill engine driving the VRAM write port, one pixel per clock.
// Optional on-screen clipping is enabled by defining VRAM_FILL_CLIP_EN.
`timescale 1ns/1ps

module vram_fill #(
  parameter int H_RES  = 256,
  parameter int V_RES  = 256,
  parameter int ADDR_W = 16,
  parameter int CW     = 9
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CW-1:0]     cmd_x,
  input  logic [CW-1:0]     cmd_y,
  input  logic [CW-1:0]     cmd_w,
  input  logic [CW-1:0]     cmd_h,
  input  logic [23:0]       cmd_color,
  output logic [ADDR_W-1:0] vram_wadr,
  output logic              vram_we,
  output logic [23:0]       vram_d,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [CW:0] ONE = (CW+1)'(1);

  logic [1:0]        r_state;
  logic [CW:0]       r_x0;
  logic [CW:0]       r_xe;
  logic [CW:0]       r_ye;
  logic [CW:0]       r_cur_x;
  logic [CW:0]       r_cur_y;
  logic [23:0]       r_color;
  logic [ADDR_W-1:0] r_wadr;
  logic              r_we;
  logic [23:0]       r_d;
  logic              r_busy;
  logic              r_done;
  logic              r_ready;

  logic [CW:0]       w_x;
  logic [CW:0]       w_y;
  logic [CW:0]       w_weff;
  logic [CW:0]       w_heff;
  logic              w_accept;
  logic              w_empty;
  logic [ADDR_W-1:0] w_addr;

  assign w_x = {1'b0, cmd_x};
  assign w_y = {1'b0, cmd_y};

`ifdef VRAM_FILL_CLIP_EN
  localparam logic [CW:0] HR = (CW+1)'(H_RES);
  localparam logic [CW:0] VR = (CW+1)'(V_RES);

  // Clamp the size to the visible area; fully off-screen origins give zero size.
  always_comb begin
    w_weff = {1'b0, cmd_w};
    w_heff = {1'b0, cmd_h};
    if (w_x >= HR)
      w_weff = '0;
    else if (w_weff > HR - w_x)
      w_weff = HR - w_x;
    if (w_y >= VR)
      w_heff = '0;
    else if (w_heff > VR - w_y)
      w_heff = VR - w_y;
  end
`else
  assign w_weff = {1'b0, cmd_w};
  assign w_heff = {1'b0, cmd_h};
`endif

  assign w_accept = (r_state == S_IDLE) && cmd_valid && r_ready;
  assign w_empty  = (w_weff == '0) || (w_heff == '0);
  // Modular arithmetic in ADDR_W bits gives the wrapped address directly.
  assign w_addr   = ADDR_W'(r_cur_y) * ADDR_W'(H_RES) + ADDR_W'(r_cur_x);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_x0    <= '0;
      r_xe    <= '0;
      r_ye    <= '0;
      r_cur_x <= '0;
      r_cur_y <= '0;
      r_color <= '0;
      r_wadr  <= '0;
      r_we    <= 1'b0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_we   <= 1'b0;
          r_done <= 1'b0;
          if (w_accept) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_x0    <= w_x;
            r_cur_x <= w_x;
            r_cur_y <= w_y;
            r_xe    <= w_x + w_weff - ONE;
            r_ye    <= w_y + w_heff - ONE;
            r_color <= cmd_color;
            r_state <= w_empty ? S_FIN : S_FILL;
          end else begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_FILL: begin
          r_we   <= 1'b1;
          r_wadr <= w_addr;
          r_d    <= r_color;
          if (r_cur_x == r_xe) begin
            r_cur_x <= r_x0;
            if (r_cur_y == r_ye)
              r_state <= S_FIN;
            else
              r_cur_y <= r_cur_y + ONE;
          end else begin
            r_cur_x <= r_cur_x + ONE;
          end
        end
        S_FIN: begin
          // busy and cmd_ready stay put; the following IDLE cycle releases them.
          r_we    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign vram_wadr = r_wadr;
  assign vram_we   = r_we;
  assign vram_d    = r_d;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_vram_fill.sv
// Randomised self-checking bench for vram_fill against a pixel-list reference model.
`timescale 1ns/1ps

module tb_vram_fill;
  localparam int H  = 256;
  localparam int V  = 256;
  localparam int AW = 16;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_x, cmd_y, cmd_w, cmd_h;
  logic [23:0]   cmd_color;
  logic [AW-1:0] vram_wadr;
  logic          vram_we;
  logic [23:0]   vram_d;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_err    = 0;

  vram_fill #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .CW(CW)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x    (cmd_x),
    .cmd_y    (cmd_y),
    .cmd_w    (cmd_w),
    .cmd_h    (cmd_h),
    .cmd_color(cmd_color),
    .vram_wadr(vram_wadr),
    .vram_we  (vram_we),
    .vram_d   (vram_d),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: every rectangle pixel in row-major order, optionally dropping off-screen ones.
  task automatic model(input int x, y, w, h, output int q[$]);
    q = {};
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        int px, py;
        px = x + xx;
        py = y + yy;
`ifdef VRAM_FILL_CLIP_EN
        if (px >= H || py >= V) continue;
`endif
        q.push_back((py * H + px) % (1 << AW));
      end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", cmd_ready, 1);
  endtask

  task automatic perturb(input bit hold);
    cmd_x     = CW'($urandom);
    cmd_color = 24'($urandom);
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_y = CW'($urandom);
      cmd_w = CW'($urandom);
      cmd_h = CW'($urandom);
    end
  endtask

  task automatic run(input int x, y, w, h, input logic [23:0] c, input bit hold);
    int q[$];
    model(x, y, w, h, q);
    wait_ready();
    cmd_x = CW'(x); cmd_y = CW'(y); cmd_w = CW'(w); cmd_h = CW'(h);
    cmd_color = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("acc_ready", cmd_ready, 0);
    check("acc_busy", busy, 1);
    check("lat_we", vram_we, 0);
    check("lat_done", done, 0);
    perturb(hold);
    foreach (q[i]) begin
      @(negedge clk);
      check("wr_we", vram_we, 1);
      check("wr_adr", vram_wadr, q[i]);
      check("wr_dat", vram_d, c);
      check("wr_ready", cmd_ready, 0);
      perturb(hold);
    end
    @(negedge clk);
    check("fin_done", done, 1);
    check("fin_we", vram_we, 0);
    check("fin_ready", cmd_ready, 0);
    @(negedge clk);
    check("post_done", done, 0);
    check("post_ready", cmd_ready, 1);
    check("post_we", vram_we, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_we", vram_we, 0);
    check("rst_adr", vram_wadr, 0);
    check("rst_dat", vram_d, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    run(10, 20, 3, 2, 24'hFF0000, 1'b0);
    run(0, 0, 0, 5, 24'h123456, 1'b0);
    run(7, 9, 5, 0, 24'h00FF00, 1'b0);
    run(254, 255, 4, 1, 24'h0000FF, 1'b0);
    run(300, 10, 3, 2, 24'hABCDEF, 1'b0);
    // Held valid with changing inputs, then an immediate follow-on command.
    run(40, 50, 4, 3, 24'h5A5A5A, 1'b1);
    run(1, 2, 2, 2, 24'hC0FFEE, 1'b0);

    for (int i = 0; i < 30; i++)
      run($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 6),
          $urandom_range(0, 6), 24'($urandom), 1'(i % 4 == 1));

    // Reset asserted while the third write of a 4x4 fill is on the port.
    wait_ready();
    cmd_x = 9'd5; cmd_y = 9'd6; cmd_w = 9'd4; cmd_h = 9'd4; cmd_color = 24'h777777;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst3_we_pre", vram_we, 1);
    check("rst3_adr_pre", vram_wadr, 6 * H + 7);
    rst = 1'b1;
    #1;
    check("rst3_we", vram_we, 0);
    check("rst3_busy", busy, 0);
    check("rst3_ready", cmd_ready, 1);
    check("rst3_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("rst3_nodone", done, 0);
      check("rst3_nowe", vram_we, 0);
    end

    run(0, 0, 256, 256, 24'h3C3C3C, 1'b0);
    cmd_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
